function_mod: RTL and testbench



---
 rtl/function_mod_pkg.sv | 24 ++
 rtl/bit_reverse.sv | 16 +
 rtl/function_mod_checker.sv | 37 +++
 rtl/function_mod.sv | 53 +++++
 tb/tb_function_mod.sv | 148 ++++++++++++++
 5 files changed

// File: rtl/function_mod_pkg.sv
// Shared constants and the bit-order reversal helper used by function_mod.
package function_mod_pkg;

    // Operand width used when the instantiating design does not override it.
    localparam int FM_DEFAULT_WIDTH = 4;

    // Widest operand bit_rev can mirror; wider instances need this raised.
    localparam int FM_MAX_WIDTH = 64;

    // Mirror the low `width` bits of x: result bit i = x[width-1-i].
    // The operand is zero-extended to FM_MAX_WIDTH by the caller. The whole
    // vector is mirrored, which parks the useful bits at the top, and the
    // shift then brings them back down to bit 0. Any X bit moves only to its
    // mirrored position because both steps are pure bit moves.
    function automatic logic [FM_MAX_WIDTH-1:0] bit_rev(
        input logic [FM_MAX_WIDTH-1:0] x,
        input int                      width
    );
        logic [FM_MAX_WIDTH-1:0] full_rev;
        full_rev = {<<{x}};
        return full_rev >> (FM_MAX_WIDTH - width);
    endfunction

endpackage

// File: rtl/bit_reverse.sv
// Combinational lane: mirrors the bit order of one WIDTH-bit operand.
module bit_reverse
    import function_mod_pkg::*;
#(
    parameter int WIDTH = FM_DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out
);

    // Widen into the helper's fixed width, mirror, and keep the low WIDTH bits.
    always_comb begin
        out = WIDTH'(bit_rev(FM_MAX_WIDTH'(in), WIDTH));
    end

endmodule

// File: rtl/function_mod_checker.sv
// Property checks for function_mod: 1-cycle mirrored results, cleared in reset.
module function_mod_checker
    import function_mod_pkg::*;
#(
    parameter int WIDTH = FM_DEFAULT_WIDTH
) (
    input logic             clk,
    input logic             rst,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic [WIDTH-1:0] c,
    input logic [WIDTH-1:0] d
);

    // High only once a clean edge has loaded the outputs since the last reset,
    // so a reset pulse between edges does not trip the data check.
    logic loaded_r;

    // Track whether the output registers hold a value loaded from the inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            loaded_r <= 1'b0;
        end else begin
            loaded_r <= 1'b1;
        end
    end

    // Each output is the mirror of the operand sampled on the previous edge.
    assert property (@(posedge clk) disable iff (rst)
        loaded_r |-> (c == WIDTH'(bit_rev(FM_MAX_WIDTH'($past(a)), WIDTH))));
    assert property (@(posedge clk) disable iff (rst)
        loaded_r |-> (d == WIDTH'(bit_rev(FM_MAX_WIDTH'($past(b)), WIDTH))));

    // Outputs stay cleared for as long as reset is held.
    assert property (@(posedge clk) rst |-> ((c == '0) && (d == '0)));

endmodule

// File: rtl/function_mod.sv
// Bit-order reversal of two independent operands with a one-cycle register stage.
module function_mod
    import function_mod_pkg::*;
#(
    parameter int WIDTH = FM_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] d
);

    logic [WIDTH-1:0] c_next_s;
    logic [WIDTH-1:0] d_next_s;
    logic [WIDTH-1:0] c_r;
    logic [WIDTH-1:0] d_r;

    bit_reverse #(.WIDTH(WIDTH)) u_rev_a (
        .in  (a),
        .out (c_next_s)
    );

    bit_reverse #(.WIDTH(WIDTH)) u_rev_b (
        .in  (b),
        .out (d_next_s)
    );

    // Output bank: loads both mirrored lanes every edge, clears at once on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_r <= '0;
            d_r <= '0;
        end else begin
            c_r <= c_next_s;
            d_r <= d_next_s;
        end
    end

    assign c = c_r;
    assign d = d_r;

    function_mod_checker #(.WIDTH(WIDTH)) u_checker (
        .clk (clk),
        .rst (rst),
        .a   (a),
        .b   (b),
        .c   (c),
        .d   (d)
    );

endmodule

// File: tb/tb_function_mod.sv
// Directed bench for function_mod: reset, mirrored vectors, full sweep, async reset.
module tb_function_mod;

    logic       clk;
    logic       rst;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] c;
    logic [3:0] d;
    logic [0:0] a1;
    logic [0:0] b1;
    logic [0:0] c1;
    logic [0:0] d1;

    int check_cnt;
    int pass_cnt;

    function_mod #(.WIDTH(4)) u_dut (
        .clk (clk),
        .rst (rst),
        .a   (a),
        .b   (b),
        .c   (c),
        .d   (d)
    );

    function_mod #(.WIDTH(1)) u_dut_w1 (
        .clk (clk),
        .rst (rst),
        .a   (a1),
        .b   (b1),
        .c   (c1),
        .d   (d1)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference mirror for a 4-bit value, written out bit by bit.
    function automatic logic [3:0] mirror4(input logic [3:0] x);
        return {x[0], x[1], x[2], x[3]};
    endfunction

    // Count one comparison and report it if the observed value differs.
    task automatic check_eq(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        check_cnt++;
        if (obs === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %b, expected %b (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        check_cnt = 0;
        pass_cnt  = 0;
        rst = 1'b1;
        a   = 4'b1111;
        b   = 4'b1111;
        a1  = 1'b1;
        b1  = 1'b1;
        #1;
        check_eq("rst_imm_c", c, 4'b0000);
        check_eq("rst_imm_d", d, 4'b0000);
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("rst_hold_c", c, 4'b0000);
            check_eq("rst_hold_d", d, 4'b0000);
            check_eq("rst_hold_c1", {3'b000, c1}, 4'b0000);
        end

        rst = 1'b0;
        a = 4'b1010; b = 4'b0101; a1 = 1'b1; b1 = 1'b0;
        step();
        check_eq("basic_c", c, 4'b0101);
        check_eq("basic_d", d, 4'b1010);
        check_eq("w1_c", {3'b000, c1}, 4'b0001);
        check_eq("w1_d", {3'b000, d1}, 4'b0000);

        a = 4'b0101; b = 4'b1010; a1 = 1'b0; b1 = 1'b1;
        step();
        check_eq("invert_c", c, 4'b1010);
        check_eq("invert_d", d, 4'b0101);
        check_eq("w1_c2", {3'b000, c1}, 4'b0000);
        check_eq("w1_d2", {3'b000, d1}, 4'b0001);

        a = 4'b0110; b = 4'b1011;
        step();
        check_eq("incr1_c", c, 4'b0110);
        check_eq("incr1_d", d, 4'b1101);

        a = 4'b0111; b = 4'b1100;
        step();
        check_eq("incr2_c", c, 4'b1110);
        check_eq("incr2_d", d, 4'b0011);

        step();
        check_eq("held_c", c, 4'b1110);
        check_eq("held_d", d, 4'b0011);

        a = 4'b0001; b = 4'b1000;
        step();
        check_eq("edge_c", c, 4'b1000);
        check_eq("edge_d", d, 4'b0001);

        // Every (a, b) pair, one per cycle.
        for (int i = 0; i < 256; i++) begin
            logic [7:0] pair;
            pair = 8'(i);
            a = pair[7:4];
            b = pair[3:0];
            step();
            check_eq("sweep_c", c, mirror4(pair[7:4]));
            check_eq("sweep_d", d, mirror4(pair[3:0]));
        end

        // Reset pulse between edges while a = 0001.
        a = 4'b0001; b = 4'b0000;
        step();
        check_eq("pre_pulse_c", c, 4'b1000);
        #2;
        rst = 1'b1;
        #1;
        check_eq("pulse_c", c, 4'b0000);
        check_eq("pulse_d", d, 4'b0000);
        #1;
        rst = 1'b0;
        b = 4'b0011;
        #1;
        check_eq("post_pulse_hold_c", c, 4'b0000);
        step();
        check_eq("reload_c", c, 4'b1000);
        check_eq("reload_d", d, 4'b1100);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
